// File: rtl/eco32f_alu_decode_pkg.sv
// Shared definitions for the eco32f ALU decode slice: instruction field
// positions, opcode values, one-hot execute-op indices, immediate extension
// modes and the multiply-to-use hazard match helper.
package eco32f_alu_decode_pkg;

    // Instruction field bit positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RX_MSB = 25;
    localparam int RX_LSB = 21;
    localparam int RY_MSB = 20;
    localparam int RY_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcodes (register forms are even, immediate forms are register form + 1)
    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_SUBI  = 6'h03;
    localparam logic [5:0] OP_MUL   = 6'h04;
    localparam logic [5:0] OP_MULI  = 6'h05;
    localparam logic [5:0] OP_MULU  = 6'h06;
    localparam logic [5:0] OP_MULUI = 6'h07;
    localparam logic [5:0] OP_DIV   = 6'h08;
    localparam logic [5:0] OP_DIVI  = 6'h09;
    localparam logic [5:0] OP_DIVU  = 6'h0A;
    localparam logic [5:0] OP_DIVUI = 6'h0B;
    localparam logic [5:0] OP_REM   = 6'h0C;
    localparam logic [5:0] OP_REMI  = 6'h0D;
    localparam logic [5:0] OP_REMU  = 6'h0E;
    localparam logic [5:0] OP_REMUI = 6'h0F;
    localparam logic [5:0] OP_AND   = 6'h10;
    localparam logic [5:0] OP_ANDI  = 6'h11;
    localparam logic [5:0] OP_OR    = 6'h12;
    localparam logic [5:0] OP_ORI   = 6'h13;
    localparam logic [5:0] OP_XOR   = 6'h14;
    localparam logic [5:0] OP_XORI  = 6'h15;
    localparam logic [5:0] OP_XNOR  = 6'h16;
    localparam logic [5:0] OP_XNORI = 6'h17;
    localparam logic [5:0] OP_SLL   = 6'h18;
    localparam logic [5:0] OP_SLLI  = 6'h19;
    localparam logic [5:0] OP_SLR   = 6'h1A;
    localparam logic [5:0] OP_SLRI  = 6'h1B;
    localparam logic [5:0] OP_SAR   = 6'h1C;
    localparam logic [5:0] OP_SARI  = 6'h1D;
    localparam logic [5:0] OP_RSVD_1E = 6'h1E;
    localparam logic [5:0] OP_LDHI  = 6'h1F;
    localparam logic [5:0] OP_BEQ   = 6'h20;
    localparam logic [5:0] OP_BNE   = 6'h21;
    localparam logic [5:0] OP_BLE   = 6'h22;
    localparam logic [5:0] OP_BLEU  = 6'h23;
    localparam logic [5:0] OP_BLT   = 6'h24;
    localparam logic [5:0] OP_BLTU  = 6'h25;
    localparam logic [5:0] OP_BGE   = 6'h26;
    localparam logic [5:0] OP_BGEU  = 6'h27;
    localparam logic [5:0] OP_BGT   = 6'h28;
    localparam logic [5:0] OP_BGTU  = 6'h29;
    localparam logic [5:0] OP_JAL   = 6'h2C;
    localparam logic [5:0] OP_JALR  = 6'h2D;
    localparam logic [5:0] OP_RSVD_3E = 6'h3E;
    localparam logic [5:0] OP_RSVD_3F = 6'h3F;

    // One-hot execute-op indices
    localparam int EX_ADD  = 0;
    localparam int EX_SUB  = 1;
    localparam int EX_MUL  = 2;
    localparam int EX_DIV  = 3;
    localparam int EX_REM  = 4;
    localparam int EX_OR   = 5;
    localparam int EX_AND  = 6;
    localparam int EX_XOR  = 7;
    localparam int EX_XNOR = 8;
    localparam int EX_SLL  = 9;
    localparam int EX_SLR  = 10;
    localparam int EX_SAR  = 11;
    localparam int EX_BEQ  = 12;
    localparam int EX_BNE  = 13;
    localparam int EX_BLE  = 14;
    localparam int EX_BLEU = 15;
    localparam int EX_BLT  = 16;
    localparam int EX_BLTU = 17;
    localparam int EX_BGE  = 18;
    localparam int EX_BGEU = 19;
    localparam int EX_BGT  = 20;
    localparam int EX_BGTU = 21;
    localparam int EX_JAL  = 22;
    localparam int EX_RRB  = 23;
    localparam int NUM_EX_OPS = 24;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_HIGH = 2'd2
    } imm_mode_t;

    // A source collides with an in-flight multiply destination; r0 never does
    function automatic logic mul_hazard(input logic [4:0] src,
                                        input logic [4:0] ex_rd,
                                        input logic       ex_mul,
                                        input logic [4:0] mem_rd);
        return (src != 5'd0) && ((ex_mul && (src == ex_rd)) || (src == mem_rd));
    endfunction

endpackage

// File: rtl/eco32f_imm_ext.sv
// Combinational immediate extender: sign-extend, zero-extend, or place the
// 16-bit immediate in the upper half (load-high).
module eco32f_imm_ext
    import eco32f_alu_decode_pkg::*;
(
    input  logic [15:0] imm16,
    input  logic [1:0]  imm_mode,
    output logic [31:0] imm
);

    // Select the extension selected by the decoder, sign-extension by default
    always_comb begin
        imm = {{16{imm16[15]}}, imm16};
        case (imm_mode)
            IMM_ZEXT: imm = {16'h0000, imm16};
            IMM_HIGH: imm = {imm16, 16'h0000};
            default:  imm = {{16{imm16[15]}}, imm16};
        endcase
    end

endmodule

// File: rtl/eco32f_alu_decode.sv
// ID/EX producer for the eco32f execute-stage ALU. Decodes the ID instruction
// into one-hot ALU controls, immediate, register indices and signed-divide
// flag, registers them into EX, and raises the mul-to-use interlock because
// a multiply result is only available in WB.
// Optional feature: define ECO32F_DECODE_ILLEGAL_EN to pass undecodable
// opcodes into EX as valid instructions flagged ex_illegal.
module eco32f_alu_decode
    import eco32f_alu_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_insn,
    input  logic        id_stall,
    input  logic        ex_stall,
    input  logic        mem_stall,
    input  logic        ex_flush,
    output logic        id_hazard_stall,
    output logic        ex_valid,
    output logic        ex_op_add,
    output logic        ex_op_sub,
    output logic        ex_op_mul,
    output logic        ex_op_div,
    output logic        ex_op_rem,
    output logic        ex_op_or,
    output logic        ex_op_and,
    output logic        ex_op_xor,
    output logic        ex_op_xnor,
    output logic        ex_op_sll,
    output logic        ex_op_slr,
    output logic        ex_op_sar,
    output logic        ex_op_beq,
    output logic        ex_op_bne,
    output logic        ex_op_ble,
    output logic        ex_op_bleu,
    output logic        ex_op_blt,
    output logic        ex_op_bltu,
    output logic        ex_op_bge,
    output logic        ex_op_bgeu,
    output logic        ex_op_bgt,
    output logic        ex_op_bgtu,
    output logic        ex_op_jal,
    output logic        ex_op_rrb,
    output logic        ex_signed_div,
    output logic [31:0] ex_imm,
    output logic        ex_imm_sel,
    output logic [4:0]  ex_rx,
    output logic [4:0]  ex_ry,
    output logic [4:0]  ex_rd,
    output logic        ex_illegal
);

    logic [5:0]            op;
    logic [4:0]            f_rx;
    logic [4:0]            f_ry;
    logic [4:0]            f_rd;

    logic [NUM_EX_OPS-1:0] dec_ops;
    logic [4:0]            dec_rx;
    logic [4:0]            dec_rd;
    logic                  dec_imm_sel;
    logic                  dec_signed_div;
    logic                  dec_uses_ry;
    logic                  dec_zext_group;
    logic                  dec_rsvd;
    logic                  dec_load;
    imm_mode_t             dec_imm_mode;
    logic [31:0]           dec_imm;

    logic [NUM_EX_OPS-1:0] ex_ops;
    logic [4:0]            mem_mul_rd;
    logic                  load_bubble;

    assign op   = id_insn[OP_MSB:OP_LSB];
    assign f_rx = id_insn[RX_MSB:RX_LSB];
    assign f_ry = id_insn[RY_MSB:RY_LSB];
    assign f_rd = id_insn[RD_MSB:RD_LSB];

    // Decode the ID instruction into ALU controls, indices and immediate mode
    always_comb begin
        dec_ops        = '0;
        dec_rx         = f_rx;
        dec_rd         = 5'd0;
        dec_imm_sel    = 1'b0;
        dec_signed_div = 1'b0;
        dec_uses_ry    = 1'b0;
        dec_zext_group = 1'b0;
        dec_rsvd       = 1'b0;
        dec_imm_mode   = IMM_SEXT;

        if (op <= OP_SARI) begin
            dec_imm_sel = op[0];
            dec_uses_ry = ~op[0];
            dec_rd      = op[0] ? f_ry : f_rd;
        end

        case (op)
            OP_ADD,  OP_ADDI:  dec_ops[EX_ADD] = 1'b1;
            OP_SUB,  OP_SUBI:  dec_ops[EX_SUB] = 1'b1;
            OP_MUL,  OP_MULI:  dec_ops[EX_MUL] = 1'b1;
            OP_MULU, OP_MULUI: begin
                dec_ops[EX_MUL] = 1'b1;
                dec_zext_group  = 1'b1;
            end
            OP_DIV,  OP_DIVI: begin
                dec_ops[EX_DIV] = 1'b1;
                dec_signed_div  = 1'b1;
            end
            OP_DIVU, OP_DIVUI: begin
                dec_ops[EX_DIV] = 1'b1;
                dec_zext_group  = 1'b1;
            end
            OP_REM,  OP_REMI: begin
                dec_ops[EX_REM] = 1'b1;
                dec_signed_div  = 1'b1;
            end
            OP_REMU, OP_REMUI: begin
                dec_ops[EX_REM] = 1'b1;
                dec_zext_group  = 1'b1;
            end
            OP_AND,  OP_ANDI: begin
                dec_ops[EX_AND] = 1'b1;
                dec_zext_group  = 1'b1;
            end
            OP_OR,   OP_ORI: begin
                dec_ops[EX_OR]  = 1'b1;
                dec_zext_group  = 1'b1;
            end
            OP_XOR,  OP_XORI: begin
                dec_ops[EX_XOR] = 1'b1;
                dec_zext_group  = 1'b1;
            end
            OP_XNOR, OP_XNORI: begin
                dec_ops[EX_XNOR] = 1'b1;
                dec_zext_group   = 1'b1;
            end
            OP_SLL,  OP_SLLI:  dec_ops[EX_SLL] = 1'b1;
            OP_SLR,  OP_SLRI:  dec_ops[EX_SLR] = 1'b1;
            OP_SAR,  OP_SARI:  dec_ops[EX_SAR] = 1'b1;
            OP_LDHI: begin
                dec_ops[EX_ADD] = 1'b1;
                dec_rx          = 5'd0;
                dec_rd          = f_ry;
                dec_imm_sel     = 1'b1;
            end
            OP_BEQ:  dec_ops[EX_BEQ]  = 1'b1;
            OP_BNE:  dec_ops[EX_BNE]  = 1'b1;
            OP_BLE:  dec_ops[EX_BLE]  = 1'b1;
            OP_BLEU: dec_ops[EX_BLEU] = 1'b1;
            OP_BLT:  dec_ops[EX_BLT]  = 1'b1;
            OP_BLTU: dec_ops[EX_BLTU] = 1'b1;
            OP_BGE:  dec_ops[EX_BGE]  = 1'b1;
            OP_BGEU: dec_ops[EX_BGEU] = 1'b1;
            OP_BGT:  dec_ops[EX_BGT]  = 1'b1;
            OP_BGTU: dec_ops[EX_BGTU] = 1'b1;
            OP_JAL, OP_JALR: begin
                dec_ops[EX_JAL] = 1'b1;
                dec_rd          = LINK_REG;
            end
            OP_RSVD_1E, OP_RSVD_3E, OP_RSVD_3F: dec_rsvd = 1'b1;
            default: ;
        endcase

        if ((op >= OP_BEQ) && (op <= OP_BGTU)) begin
            dec_ops[EX_RRB] = 1'b1;
            dec_uses_ry     = 1'b1;
        end

        if (op == OP_LDHI) begin
            dec_imm_mode = IMM_HIGH;
        end else if (dec_zext_group && op[0]) begin
            dec_imm_mode = IMM_ZEXT;
        end else begin
            dec_imm_mode = IMM_SEXT;
        end
    end

`ifdef ECO32F_DECODE_ILLEGAL_EN
    assign dec_load = 1'b1;
`else
    assign dec_load = ~dec_rsvd;
`endif

    eco32f_imm_ext u_imm_ext (
        .imm16    (id_insn[IMM_MSB:IMM_LSB]),
        .imm_mode (dec_imm_mode),
        .imm      (dec_imm)
    );

    // Interlock when a source reads a multiply destination still in EX or MEM
    always_comb begin
        id_hazard_stall = id_valid &&
            (mul_hazard(dec_rx, ex_rd, ex_op_mul, mem_mul_rd) ||
             (dec_uses_ry && mul_hazard(f_ry, ex_rd, ex_op_mul, mem_mul_rd)));
    end

    assign load_bubble = ex_flush | id_stall | id_hazard_stall | ~id_valid | ~dec_load;

    // EX register: reset, hold on ex_stall, bubble when nothing may enter, else load
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_ops        <= '0;
            ex_signed_div <= 1'b0;
            ex_imm        <= 32'h0;
            ex_imm_sel    <= 1'b0;
            ex_rx         <= 5'd0;
            ex_ry         <= 5'd0;
            ex_rd         <= 5'd0;
        end else if (!ex_stall) begin
            if (load_bubble) begin
                ex_valid      <= 1'b0;
                ex_ops        <= '0;
                ex_signed_div <= 1'b0;
                ex_imm        <= 32'h0;
                ex_imm_sel    <= 1'b0;
                ex_rx         <= 5'd0;
                ex_ry         <= 5'd0;
                ex_rd         <= 5'd0;
            end else begin
                ex_valid      <= 1'b1;
                ex_ops        <= dec_ops;
                ex_signed_div <= dec_signed_div;
                ex_imm        <= dec_imm;
                ex_imm_sel    <= dec_imm_sel;
                ex_rx         <= dec_rx;
                ex_ry         <= f_ry;
                ex_rd         <= dec_rd;
            end
        end
    end

`ifdef ECO32F_DECODE_ILLEGAL_EN
    // Illegal flag travels with the EX register under the same update rules
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_illegal <= 1'b0;
        end else if (!ex_stall) begin
            ex_illegal <= ~load_bubble & dec_rsvd;
        end
    end
`else
    assign ex_illegal = 1'b0;
`endif

    // Track the destination of a multiply moving into MEM (result appears in WB)
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_mul_rd <= 5'd0;
        end else if (!ex_stall) begin
            if (mem_stall) begin
                mem_mul_rd <= 5'd0;
            end else begin
                mem_mul_rd <= (ex_op_mul && ex_valid) ? ex_rd : 5'd0;
            end
        end
    end

    assign ex_op_add  = ex_ops[EX_ADD];
    assign ex_op_sub  = ex_ops[EX_SUB];
    assign ex_op_mul  = ex_ops[EX_MUL];
    assign ex_op_div  = ex_ops[EX_DIV];
    assign ex_op_rem  = ex_ops[EX_REM];
    assign ex_op_or   = ex_ops[EX_OR];
    assign ex_op_and  = ex_ops[EX_AND];
    assign ex_op_xor  = ex_ops[EX_XOR];
    assign ex_op_xnor = ex_ops[EX_XNOR];
    assign ex_op_sll  = ex_ops[EX_SLL];
    assign ex_op_slr  = ex_ops[EX_SLR];
    assign ex_op_sar  = ex_ops[EX_SAR];
    assign ex_op_beq  = ex_ops[EX_BEQ];
    assign ex_op_bne  = ex_ops[EX_BNE];
    assign ex_op_ble  = ex_ops[EX_BLE];
    assign ex_op_bleu = ex_ops[EX_BLEU];
    assign ex_op_blt  = ex_ops[EX_BLT];
    assign ex_op_bltu = ex_ops[EX_BLTU];
    assign ex_op_bge  = ex_ops[EX_BGE];
    assign ex_op_bgeu = ex_ops[EX_BGEU];
    assign ex_op_bgt  = ex_ops[EX_BGT];
    assign ex_op_bgtu = ex_ops[EX_BGTU];
    assign ex_op_jal  = ex_ops[EX_JAL];
    assign ex_op_rrb  = ex_ops[EX_RRB];

endmodule
